// File: rtl/order_queue_retire_if.sv
// Order-queue / CDB / register-file bundle seen by the in-order retirement controller.
// The master side drives the queue head, CDB and flush; the slave side is the controller.
interface order_queue_retire_if #(
  parameter int TAG_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR   = 5,
  parameter int CNT_WIDTH  = 16
);
  logic                  oq_valid;
  logic [TAG_WIDTH-1:0]  oq_tag;
  logic                  oq_pop;
  logic                  cdb_valid;
  logic [TAG_WIDTH-1:0]  cdb_tag;
  logic [REG_ADDR-1:0]   cdb_rd;
  logic [DATA_WIDTH-1:0] cdb_data;
  logic                  flush;
  logic                  rf_we;
  logic [REG_ADDR-1:0]   rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  tag_free_valid;
  logic [TAG_WIDTH-1:0]  tag_free_tag;
  logic [CNT_WIDTH-1:0]  retire_count;

  modport master (
    output oq_valid, oq_tag, cdb_valid, cdb_tag, cdb_rd, cdb_data, flush,
    input  oq_pop, rf_we, rf_waddr, rf_wdata, tag_free_valid, tag_free_tag, retire_count
  );

  modport slave (
    input  oq_valid, oq_tag, cdb_valid, cdb_tag, cdb_rd, cdb_data, flush,
    output oq_pop, rf_we, rf_waddr, rf_wdata, tag_free_valid, tag_free_tag, retire_count
  );
endinterface

// File: rtl/order_queue_retire.sv
// In-order retirement controller: records CDB completions per tag and retires the
// order-queue head (pop, register write, tag free) once its tag has completed.
module order_queue_retire #(
  parameter int TAG_WIDTH  = 5,
  parameter int NUM_TAGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR   = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic               clk,
  input  logic               rst,
  order_queue_retire_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    RETIRE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [31:0] NUM_TAGS_U = 32'(NUM_TAGS);

  state_t                state_r;
  logic [NUM_TAGS-1:0]   done_r;
  logic [REG_ADDR-1:0]   rd_r   [NUM_TAGS];
  logic [DATA_WIDTH-1:0] data_r [NUM_TAGS];
  logic [TAG_WIDTH-1:0]  hold_tag_r;
  logic [REG_ADDR-1:0]   hold_rd_r;
  logic [DATA_WIDTH-1:0] hold_data_r;
  logic [CNT_WIDTH-1:0]  count_r;

  logic                  cdb_hit_s;
  logic                  head_done_s;
  logic                  retiring_s;

  function automatic logic tag_in_range(input logic [TAG_WIDTH-1:0] tag);
    return 32'(tag) < NUM_TAGS_U;
  endfunction

  // Table lookups; the head sees only completions written on earlier edges.
  always_comb begin
    cdb_hit_s   = bus.cdb_valid && tag_in_range(bus.cdb_tag);
    head_done_s = 1'b0;
    if (tag_in_range(bus.oq_tag)) begin
      head_done_s = done_r[bus.oq_tag];
    end else begin
      head_done_s = 1'b0;
    end
    retiring_s  = (state_r == RETIRE);
  end

  // Completion table: the CDB set is written last so it beats a same-tag retire clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_r <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        rd_r[i]   <= '0;
        data_r[i] <= '0;
      end
    end else if (bus.flush) begin
      done_r <= '0;
    end else begin
      if (retiring_s) begin
        done_r[hold_tag_r] <= 1'b0;
      end
      if (cdb_hit_s) begin
        done_r[bus.cdb_tag] <= 1'b1;
        rd_r[bus.cdb_tag]   <= bus.cdb_rd;
        data_r[bus.cdb_tag] <= bus.cdb_data;
      end
    end
  end

  // Retirement sequencer with its holding registers and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= WAIT;
      hold_tag_r  <= '0;
      hold_rd_r   <= '0;
      hold_data_r <= '0;
      count_r     <= '0;
    end else if (bus.flush) begin
      state_r <= WAIT;
    end else begin
      case (state_r)
        WAIT: begin
          if (bus.oq_valid && head_done_s) begin
            hold_tag_r  <= bus.oq_tag;
            hold_rd_r   <= rd_r[bus.oq_tag];
            hold_data_r <= data_r[bus.oq_tag];
            state_r     <= RETIRE;
          end
        end
        RETIRE: begin
          count_r <= count_r + CNT_WIDTH'(1);
          state_r <= SETTLE;
        end
        SETTLE:  state_r <= WAIT;
        default: state_r <= WAIT;
      endcase
    end
  end

  // Strobes come straight from state; a flush in RETIRE cancels them in that same cycle.
  always_comb begin
    bus.oq_pop         = retiring_s && !bus.flush;
    bus.rf_we          = retiring_s && !bus.flush;
    bus.tag_free_valid = retiring_s && !bus.flush;
    if (retiring_s) begin
      bus.rf_waddr     = hold_rd_r;
      bus.rf_wdata     = hold_data_r;
      bus.tag_free_tag = hold_tag_r;
    end else begin
      bus.rf_waddr     = '0;
      bus.rf_wdata     = '0;
      bus.tag_free_tag = '0;
    end
    bus.retire_count   = count_r;
  end

endmodule

// File: tb/tb_order_queue_retire.sv
// Directed bench for order_queue_retire: a cycle-indexed reference model checked every
// cycle, plus literal expectations for the reset, retire, ordering, flush and wrap cases.
`timescale 1ns/1ps
module tb_order_queue_retire;
  localparam int TW = 5;
  localparam int NT = 32;
  localparam int DW = 32;
  localparam int RA = 5;
  localparam int CW = 8;  // narrow counter so the wrap is reachable in a short run

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  order_queue_retire_if #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .REG_ADDR(RA), .CNT_WIDTH(CW)) bus();

  order_queue_retire #(
    .TAG_WIDTH(TW), .NUM_TAGS(NT), .DATA_WIDTH(DW), .REG_ADDR(RA), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: cycle k starts at posedge number k. A retirement chosen at edge k
  // shows its strobes in cycle k and blocks the next choice until edge k+3.
  int          cyc = 0;
  int          ret_cycle = -100;
  int          next_ok = 0;
  bit          m_done [NT];
  int          m_rd   [NT];
  logic [31:0] m_data [NT];
  int          m_count = 0;
  int          r_tag = 0;
  int          r_rd = 0;
  logic [31:0] r_data = 32'h0;

  int          pop_count = 0;
  int          pop_tags [$];
  int          pop_cyc  [$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < NT; i++) m_done[i] = 1'b0;
      m_count   = 0;
      ret_cycle = -100;
      next_ok   = cyc + 1;
    end else if (bus.flush) begin
      for (int i = 0; i < NT; i++) m_done[i] = 1'b0;
      ret_cycle = -100;
      next_ok   = cyc + 1;
    end else begin
      if (ret_cycle == cyc - 1) begin
        m_count = (m_count + 1) % (1 << CW);
        m_done[r_tag] = 1'b0;
      end
      if (cyc >= next_ok && bus.oq_valid && m_done[int'(bus.oq_tag)]) begin
        r_tag     = int'(bus.oq_tag);
        r_rd      = m_rd[r_tag];
        r_data    = m_data[r_tag];
        ret_cycle = cyc;
        next_ok   = cyc + 3;
      end
      if (bus.cdb_valid && int'(bus.cdb_tag) < NT) begin
        m_done[int'(bus.cdb_tag)] = 1'b1;
        m_rd[int'(bus.cdb_tag)]   = int'(bus.cdb_rd);
        m_data[int'(bus.cdb_tag)] = bus.cdb_data;
      end
    end
  end

  always @(negedge clk) begin
    bit ret;
    bit strobe;
    ret    = !rst && (ret_cycle == cyc);
    strobe = ret && !bus.flush;
    check("oq_pop",         bus.oq_pop,         strobe);
    check("rf_we",          bus.rf_we,          strobe);
    check("tag_free_valid", bus.tag_free_valid, strobe);
    check("rf_waddr",       bus.rf_waddr,       ret ? r_rd : 0);
    check("rf_wdata",       bus.rf_wdata,       ret ? r_data : 32'h0);
    check("tag_free_tag",   bus.tag_free_tag,   ret ? r_tag : 0);
    check("retire_count",   bus.retire_count,   rst ? 0 : m_count);
    if (bus.oq_pop === 1'b1) begin
      pop_count++;
      pop_tags.push_back(int'(bus.tag_free_tag));
      pop_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cdb_off();
    bus.cdb_valid = 1'b0;
    bus.cdb_tag   = '0;
    bus.cdb_rd    = '0;
    bus.cdb_data  = '0;
  endtask

  task automatic cdb(input int tag, input int rd, input logic [31:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = TW'(tag);
    bus.cdb_rd    = RA'(rd);
    bus.cdb_data  = data;
  endtask

  task automatic head(input bit valid, input int tag);
    bus.oq_valid = valid;
    bus.oq_tag   = TW'(tag);
  endtask

  initial begin
    int  base;
    int  c0;
    int  n;
    bit  found;
    for (int i = 0; i < NT; i++) begin
      m_rd[i]   = 0;
      m_data[i] = 32'h0;
    end
    head(1'b0, 0);
    cdb_off();
    bus.flush = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_count", bus.retire_count, 0);
    check("reset_pop", bus.oq_pop, 1'b0);

    // Reset arriving in the middle of a retirement.
    cdb(2, 1, 32'h0000_0011);
    tick();
    cdb_off();
    head(1'b1, 2);
    tick();
    check("t1_in_retire_pop", bus.oq_pop, 1'b1);
    rst = 1'b1;
    #1;
    check("t1_rst_pop", bus.oq_pop, 1'b0);
    check("t1_rst_we", bus.rf_we, 1'b0);
    check("t1_rst_free", bus.tag_free_valid, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("t1_count_after_rst", bus.retire_count, 0);
    base = pop_count;
    repeat (5) tick();
    check("t1_table_empty_pops", pop_count - base, 0);
    head(1'b0, 0);
    tick();

    // Basic retirement of tag 3.
    cdb(3, 7, 32'hDEAD_BEEF);
    tick();
    cdb_off();
    head(1'b1, 3);
    tick();
    check("t2_pop", bus.oq_pop, 1'b1);
    check("t2_waddr", bus.rf_waddr, 7);
    check("t2_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
    check("t2_free_tag", bus.tag_free_tag, 3);
    head(1'b0, 0);
    tick();
    check("t2_settle_pop", bus.oq_pop, 1'b0);
    check("t2_count", bus.retire_count, 1);

    // A younger completion must wait behind the head.
    head(1'b1, 5);
    cdb(6, 6, 32'h0000_0066);
    tick();
    cdb_off();
    base = pop_count;
    repeat (3) tick();
    check("t3_blocked_pops", pop_count - base, 0);
    cdb(5, 5, 32'h0000_0055);
    tick();
    cdb_off();
    tick();
    head(1'b1, 6);
    repeat (3) tick();
    head(1'b0, 0);
    repeat (2) tick();
    n = pop_tags.size();
    check("t3_pop_total", pop_count - base, 2);
    check("t3_first_tag", pop_tags[n-2], 5);
    check("t3_second_tag", pop_tags[n-1], 6);
    check("t3_spacing", pop_cyc[n-1] - pop_cyc[n-2], 3);

    // Empty queue holds off a completed tag.
    cdb(9, 9, 32'h0000_0099);
    tick();
    cdb_off();
    base = pop_count;
    repeat (20) tick();
    check("t4_empty_pops", pop_count - base, 0);
    head(1'b1, 9);
    tick();
    check("t4_pop", bus.oq_pop, 1'b1);
    check("t4_free_tag", bus.tag_free_tag, 9);
    head(1'b0, 0);
    tick();

    // Flush in RETIRE aborts it, clears the table and drops a same-cycle CDB.
    cdb(10, 10, 32'h0000_00AA);
    tick();
    cdb(11, 11, 32'h0000_00BB);
    head(1'b1, 10);
    tick();
    c0 = int'(bus.retire_count);
    bus.flush = 1'b1;
    cdb(12, 12, 32'h0000_00CC);
    #1;
    check("t5_flush_pop", bus.oq_pop, 1'b0);
    check("t5_flush_we", bus.rf_we, 1'b0);
    check("t5_flush_free", bus.tag_free_valid, 1'b0);
    tick();
    bus.flush = 1'b0;
    cdb_off();
    check("t5_count_kept", bus.retire_count, c0);
    base = pop_count;
    repeat (4) tick();
    head(1'b1, 11);
    repeat (4) tick();
    head(1'b1, 12);
    repeat (4) tick();
    check("t5_no_pops_after_flush", pop_count - base, 0);
    head(1'b0, 0);
    tick();

    // Same-tag completion during RETIRE keeps the tag done, then run the counter to wrap.
    cdb(4, 4, 32'h0000_0044);
    tick();
    cdb_off();
    head(1'b1, 4);
    tick();
    check("t6_first_pop", bus.oq_pop, 1'b1);
    cdb(4, 4, 32'h0000_0045);
    tick();
    cdb_off();
    tick();
    tick();
    check("t6_repeat_pop", bus.oq_pop, 1'b1);
    check("t6_repeat_tag", bus.tag_free_tag, 4);
    check("t6_repeat_data", bus.rf_wdata, 32'h0000_0045);
    cdb(4, 4, 32'h0000_0046);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      tick();
      if (bus.retire_count == CW'(8'hFF)) found = 1'b1;
    end
    check("t6_reached_max", found, 1'b1);
    repeat (3) tick();
    check("t6_wrap_zero", bus.retire_count, 0);
    cdb_off();
    head(1'b0, 0);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
